fraction_part: RTL and testbench

// - Pipelined IEEE-754 fractional-part extractor: c = a - trunc(a), with the sign of a kept.
// - Complement of the integer-part block. Same port shape and PRECISION selection.
// - Used in the Precision library for modf-style ops, range reduction and phase wrap.
// - Fully pipelined: accepts one operand per clock, no backpressure.

---
 rtl/fraction_part.sv | 169 ++++++++++++++++
 tb/tb_fraction_part.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/fraction_part.sv
// Pipelined IEEE-754 fractional-part extractor, c = a - trunc(a) with the sign of a kept.
// Optional macro FRACTION_PART_FLAGS_EN adds a registered is_integer output aligned with c.
module fraction_part #(
    parameter int    BITS      = 16,
    parameter string PRECISION = "HALF"
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            in_valid,
    input  logic [BITS-1:0] a,
    output logic            out_valid,
    output logic [BITS-1:0] c
`ifdef FRACTION_PART_FLAGS_EN
    ,
    output logic            is_integer
`endif
);

    localparam bit IS_SINGLE = (PRECISION == "SINGLE");
    localparam int EW        = IS_SINGLE ? 8 : 5;
    localparam int MW        = IS_SINGLE ? 23 : 10;
    localparam int BIAS      = IS_SINGLE ? 127 : 15;
    localparam int LZW       = $clog2(MW + 1);
    localparam int XW        = EW + 2;
    localparam logic [BITS-1:0] QNAN = {1'b0, {EW{1'b1}}, 1'b1, {(MW-1){1'b0}}};

    generate
        if (!((PRECISION == "HALF" && BITS == 16) || (PRECISION == "SINGLE" && BITS == 32))) begin : g_bad_cfg
            $error("fraction_part: unsupported PRECISION/BITS pairing");
        end
    endgenerate

    typedef enum logic [2:0] {
        CL_ZERO, CL_SUB, CL_NAN, CL_INF, CL_SMALL, CL_BIG, CL_MID
    } class_e;

    // ---------------- S1: unpack and classify ----------------
    logic [EW-1:0]        exp_w;
    logic [MW-1:0]        man_w;
    logic signed [XW-1:0] unb_w;
    class_e               cls_d;
    logic [MW-1:0]        frac_d;

    assign exp_w = a[MW +: EW];
    assign man_w = a[MW-1:0];
    assign unb_w = signed'(XW'(exp_w)) - signed'(XW'(BIAS));

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        cls_d  = CL_MID;
        frac_d = '0;
        if (exp_w == '0)
            cls_d = (man_w == '0) ? CL_ZERO : CL_SUB;
        else if (&exp_w)
            cls_d = (man_w == '0) ? CL_INF : CL_NAN;
        else if (unb_w < 0)
            cls_d = CL_SMALL;
        else if (unb_w >= signed'(XW'(MW)))
            cls_d = CL_BIG;
        else
            // Implicit 1 and the top E mantissa bits are the integer part.
            frac_d = man_w & ({MW{1'b1}} >> unb_w[LZW-1:0]);
    end

    logic            s1_valid_q;
    logic [BITS-1:0] s1_a_q;
    class_e          s1_cls_q;
    logic [LZW-1:0]  s1_e_q;
    logic [MW-1:0]   s1_frac_q;

    // ---------------- S2: leading-zero count ----------------
    logic [LZW-1:0] lz_d;
    logic           fz_d;

    always_comb begin
        lz_d = LZW'(MW);
        for (int i = 0; i < MW; i++)
            if (s1_frac_q[i]) lz_d = LZW'(MW - 1 - i);
    end
    assign fz_d = (s1_frac_q == '0);

    logic            s2_valid_q;
    logic [BITS-1:0] s2_a_q;
    class_e          s2_cls_q;
    logic [LZW-1:0]  s2_e_q;
    logic [MW-1:0]   s2_frac_q;
    logic [LZW-1:0]  s2_lz_q;
    logic            s2_fz_q;

    // ---------------- S3: assemble result ----------------
    logic [MW-1:0]   mant_w;
    logic [EW-1:0]   rexp_w;
    logic [BITS-1:0] result_d;
    logic [BITS-1:0] szero_w;

    // Value is frac * 2^(E-MW); the leading one sits at 2^(E-lz-1), always a normal number.
    assign mant_w  = s2_frac_q << (s2_lz_q + LZW'(1));
    assign rexp_w  = EW'(BIAS) + EW'(s2_e_q) - EW'(s2_lz_q) - EW'(1);
    assign szero_w = {s2_a_q[BITS-1], {(BITS-1){1'b0}}};

    always_comb begin
        result_d = '0;
        case (s2_cls_q)
            CL_ZERO, CL_SUB, CL_SMALL: result_d = s2_a_q;
            CL_INF, CL_BIG:            result_d = szero_w;
            CL_NAN:                    result_d = QNAN;
            CL_MID:                    result_d = s2_fz_q ? szero_w
                                                          : {s2_a_q[BITS-1], rexp_w, mant_w};
            default:                   result_d = '0;
        endcase
    end

`ifdef FRACTION_PART_FLAGS_EN
    logic isint_d;
    logic is_integer_q;
    assign isint_d = (s2_cls_q == CL_ZERO) || (s2_cls_q == CL_INF) || (s2_cls_q == CL_BIG) ||
                     ((s2_cls_q == CL_MID) && s2_fz_q);
    assign is_integer = is_integer_q;
`endif

    logic            out_valid_q;
    logic [BITS-1:0] c_q;

    // ---------------- Registers ----------------
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            s1_valid_q   <= 1'b0;
            s2_valid_q   <= 1'b0;
            out_valid_q  <= 1'b0;
            c_q          <= '0;
`ifdef FRACTION_PART_FLAGS_EN
            is_integer_q <= 1'b0;
`endif
        end else begin
            s1_valid_q  <= in_valid;
            s2_valid_q  <= s1_valid_q;
            out_valid_q <= s2_valid_q;
            if (s2_valid_q) begin
                c_q          <= result_d;
`ifdef FRACTION_PART_FLAGS_EN
                is_integer_q <= isint_d;
`endif
            end
        end
    end

    // NOTE: inner data registers carry no reset; their contents are ignored until the
    // matching valid bit, which is reset, marks them live.
    always_ff @(posedge clk) begin
        if (in_valid) begin
            s1_a_q    <= a;
            s1_cls_q  <= cls_d;
            s1_e_q    <= unb_w[LZW-1:0];
            s1_frac_q <= frac_d;
        end
        if (s1_valid_q) begin
            s2_a_q    <= s1_a_q;
            s2_cls_q  <= s1_cls_q;
            s2_e_q    <= s1_e_q;
            s2_frac_q <= s1_frac_q;
            s2_lz_q   <= lz_d;
            s2_fz_q   <= fz_d;
        end
    end

    assign out_valid = out_valid_q;
    assign c         = c_q;

endmodule

// File: tb/tb_fraction_part.sv
// Scoreboard bench for fraction_part: HALF and SINGLE instances, directed vectors,
// latency/order checks and mid-flight reset. Checks is_integer when FRACTION_PART_FLAGS_EN is set.
module tb_fraction_part;

    logic        clk = 1'b0;
    logic        rstn;
    logic        in_valid_h, in_valid_s;
    logic [15:0] a_h, c_h;
    logic [31:0] a_s, c_s;
    logic        out_valid_h, out_valid_s;
`ifdef FRACTION_PART_FLAGS_EN
    logic        is_integer_h, is_integer_s;
`endif

    always #5 clk = ~clk;

    fraction_part #(.BITS(16), .PRECISION("HALF")) u_half (
        .clk(clk), .rstn(rstn), .in_valid(in_valid_h), .a(a_h),
        .out_valid(out_valid_h), .c(c_h)
`ifdef FRACTION_PART_FLAGS_EN
        , .is_integer(is_integer_h)
`endif
    );

    fraction_part #(.BITS(32), .PRECISION("SINGLE")) u_single (
        .clk(clk), .rstn(rstn), .in_valid(in_valid_s), .a(a_s),
        .out_valid(out_valid_s), .c(c_s)
`ifdef FRACTION_PART_FLAGS_EN
        , .is_integer(is_integer_s)
`endif
    );

    typedef struct {
        logic [31:0] data;
        logic        isint;
        int          cyc;
    } exp_t;

    exp_t q_h[$];
    exp_t q_s[$];
    int   n_vec  = 0;
    int   n_miss = 0;
    int   cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_miss++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitors: pop and compare whenever a DUT presents an output.
    always @(negedge clk) begin
        if (out_valid_h) begin
            if (q_h.size() == 0) begin
                n_vec++;
                n_miss++;
                $display("FAIL half_spurious: out_valid=1 c=%h, expected no output", c_h);
            end else begin
                exp_t e;
                e = q_h.pop_front();
                check("half_c", {16'h0, c_h}, e.data);
                check("half_latency", 32'(cyc), 32'(e.cyc));
`ifdef FRACTION_PART_FLAGS_EN
                check("half_is_integer", {31'h0, is_integer_h}, {31'h0, e.isint});
`endif
            end
        end
    end

    always @(negedge clk) begin
        if (out_valid_s) begin
            if (q_s.size() == 0) begin
                n_vec++;
                n_miss++;
                $display("FAIL single_spurious: out_valid=1 c=%h, expected no output", c_s);
            end else begin
                exp_t e;
                e = q_s.pop_front();
                check("single_c", c_s, e.data);
                check("single_latency", 32'(cyc), 32'(e.cyc));
`ifdef FRACTION_PART_FLAGS_EN
                check("single_is_integer", {31'h0, is_integer_s}, {31'h0, e.isint});
`endif
            end
        end
    end

    // Inputs change on the falling edge; the result is due three rising edges later.
    task automatic issue_h(input logic [15:0] v, input logic [15:0] r, input logic ii);
        exp_t e;
        @(negedge clk);
        in_valid_h = 1'b1;
        a_h        = v;
        e.data     = {16'h0, r};
        e.isint    = ii;
        e.cyc      = cyc + 3;
        q_h.push_back(e);
    endtask

    task automatic issue_s(input logic [31:0] v, input logic [31:0] r, input logic ii);
        exp_t e;
        @(negedge clk);
        in_valid_s = 1'b1;
        a_s        = v;
        e.data     = r;
        e.isint    = ii;
        e.cyc      = cyc + 3;
        q_s.push_back(e);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            in_valid_h = 1'b0;
            in_valid_s = 1'b0;
        end
    endtask

    task automatic drain();
        int t = 0;
        while ((q_h.size() != 0 || q_s.size() != 0) && t < 20) begin
            @(negedge clk);
            t++;
        end
        @(negedge clk);
        n_vec++;
        if (q_h.size() != 0 || q_s.size() != 0) begin
            n_miss++;
            $display("FAIL drain_timeout: %0d half and %0d single results outstanding, expected 0",
                     q_h.size(), q_s.size());
        end
    endtask

    initial begin
        rstn       = 1'b0;
        in_valid_h = 1'b0;
        in_valid_s = 1'b0;
        a_h        = '0;
        a_s        = '0;
        #1;
        check("reset_half_out_valid",   {31'h0, out_valid_h}, 32'h0);
        check("reset_half_c",           {16'h0, c_h},         32'h0);
        check("reset_single_out_valid", {31'h0, out_valid_s}, 32'h0);
        check("reset_single_c",         c_s,                  32'h0);
        repeat (2) @(negedge clk);
        rstn = 1'b1;

        // Eight back to back.
        issue_h(16'h4180, 16'h3A00, 1'b0);
        issue_h(16'hC180, 16'hBA00, 1'b0);
        issue_h(16'h63FF, 16'h3800, 1'b0);
        issue_h(16'h4500, 16'h0000, 1'b1);
        issue_h(16'hC500, 16'h8000, 1'b1);
        issue_h(16'h7C00, 16'h0000, 1'b1);
        issue_h(16'hFC00, 16'h8000, 1'b1);
        issue_h(16'h6800, 16'h0000, 1'b1);
        // Two with gaps.
        idle(1);
        issue_h(16'h34CD, 16'h34CD, 1'b0);
        idle(2);
        issue_h(16'h0001, 16'h0001, 1'b0);
        idle(1);
        // Remaining classes and boundaries.
        issue_h(16'h8000, 16'h8000, 1'b1);
        issue_h(16'h7C01, 16'h7E00, 1'b0);
        issue_h(16'hFE00, 16'h7E00, 1'b0);
        issue_h(16'h3C00, 16'h0000, 1'b1);
        issue_h(16'h3E00, 16'h3800, 1'b0);
        issue_h(16'h6400, 16'h0000, 1'b1);
        issue_h(16'h63FE, 16'h0000, 1'b1);
        issue_h(16'hD140, 16'h8000, 1'b1);
        issue_h(16'h83FF, 16'h83FF, 1'b0);
        issue_h(16'h3BFF, 16'h3BFF, 1'b0);
        issue_h(16'h4248, 16'h3080, 1'b0);
        idle(1);
        drain();

        issue_s(32'h40300000, 32'h3F400000, 1'b0);
        issue_s(32'h4B000001, 32'h00000000, 1'b1);
        issue_s(32'h7F800001, 32'h7FC00000, 1'b0);
        issue_s(32'hC0490FDB, 32'hBE10FDB0, 1'b0);
        idle(1);
        issue_s(32'h3F800000, 32'h00000000, 1'b1);
        idle(1);
        drain();

        // Reset with two operands in flight: c drops from its held value at once.
        issue_h(16'h4180, 16'h3A00, 1'b0);
        issue_h(16'h4500, 16'h0000, 1'b1);
        @(negedge clk);
        in_valid_h = 1'b0;
        #2;
        rstn = 1'b0;
        #1;
        check("midreset_out_valid", {31'h0, out_valid_h}, 32'h0);
        check("midreset_c",         {16'h0, c_h},         32'h0);
        q_h.delete();
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        repeat (8) @(negedge clk);
        check("post_reset_c", {16'h0, c_h}, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
